// File: rtl/hsci_regmap_ctrl_pkg.sv
// Shared definitions for the HSCI register-map controller: register offsets,
// the version constant and the command-channel state encoding.
package hsci_regmap_ctrl_pkg;

  localparam int unsigned REG_CMD       = 0;
  localparam int unsigned REG_STATUS    = 1;
  localparam int unsigned REG_IRQ_MASK  = 2;
  localparam int unsigned REG_TIMEOUT   = 3;
  localparam int unsigned REG_TMO_FLAGS = 4;
  localparam int unsigned REG_VERSION   = 5;
  localparam int unsigned REG_COUNT     = 6;

  localparam logic [31:0] VERSION = 32'h0001_0000;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_RUN  = 1'b1
  } cmd_state_t;

endpackage

// File: rtl/hsci_cmd_channel.sv
// One command channel: IDLE/RUN handshake FSM, optional timeout counter and
// sticky W1C timeout flag.
// Ports:
//   clk, srstn   clock and asynchronous active-low reset
//   start_req    CMD write with this channel's bit set
//   flag_clr     W1C write to this channel's timeout flag
//   done         completion from the engine (level or pulse)
//   timeout      timeout reload value, 0 disables the timeout
//   run          busy level
//   start        single-cycle start pulse
//   tmo_flag     sticky timeout flag
module hsci_cmd_channel
  import hsci_regmap_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 srstn,
  input  logic                 start_req,
  input  logic                 flag_clr,
  input  logic                 done,
  input  logic [TIMEOUT_W-1:0] timeout,
  output logic                 run,
  output logic                 start,
  output logic                 tmo_flag
);

  cmd_state_t           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 start_d;
  logic                 flag_d;

  // State, counter, pulse and flag registers
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q  <= CMD_IDLE;
      cnt_q    <= '0;
      start    <= 1'b0;
      tmo_flag <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start    <= start_d;
      tmo_flag <= flag_d;
    end
  end

  // Next state; a zero counter in RUN means the timeout is disabled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    flag_d  = tmo_flag & ~flag_clr;
    case (state_q)
      CMD_IDLE: begin
        if (start_req) begin
          state_d = CMD_RUN;
          start_d = 1'b1;
          cnt_d   = timeout;
        end
      end
      CMD_RUN: begin
        if (done) begin
          state_d = CMD_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - TIMEOUT_W'(1);
          // Last counted cycle without done: timeout beats a same-cycle W1C
          if (cnt_q == TIMEOUT_W'(1)) begin
            state_d = CMD_IDLE;
            flag_d  = 1'b1;
          end
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  assign run = (state_q == CMD_RUN);

endmodule

// File: rtl/hsci_regmap_ctrl.sv
// Register-map control block for HSCI-class masters: NUM_CMD start/done
// command channels with timeouts, NUM_STAT sticky W1C status bits with a
// mask, and a registered interrupt.
// Ports:
//   clk, srstn            clock and asynchronous active-low reset
//   I_rd_addr             read address, sampled every cycle
//   I_wr_stb/addr/data    single-cycle write strobe interface
//   O_read_data           registered read data (1-cycle latency)
//   cmd_run, cmd_start    per-channel busy level and start pulse
//   cmd_done              per-channel completion
//   stat_event            status set requests
//   irq                   registered interrupt
module hsci_regmap_ctrl
  import hsci_regmap_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CMD    = 4,
  parameter int unsigned NUM_STAT   = 16,
  parameter int unsigned TIMEOUT_W  = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic [ADDR_WIDTH-1:0] I_rd_addr,
  input  logic                  I_wr_stb,
  input  logic [ADDR_WIDTH-1:0] I_wr_addr,
  input  logic [DATA_WIDTH-1:0] I_wr_data,
  output logic [DATA_WIDTH-1:0] O_read_data,
  output logic [NUM_CMD-1:0]    cmd_run,
  output logic [NUM_CMD-1:0]    cmd_start,
  input  logic [NUM_CMD-1:0]    cmd_done,
  input  logic [NUM_STAT-1:0]   stat_event,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH:0] BASE = (ADDR_WIDTH + 1)'(BASE_ADDR);

  logic [ADDR_WIDTH:0]   rd_diff, wr_diff;
  logic [ADDR_WIDTH-1:0] rd_off, wr_off;
  logic                  rd_hit, wr_hit;
  logic                  wr_cmd, wr_status, wr_mask, wr_timeout, wr_tmo;
  logic [NUM_STAT-1:0]   status_q, mask_q, status_clr;
  logic [TIMEOUT_W-1:0]  timeout_q;
  logic [NUM_CMD-1:0]    tmo_flags;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  unused_wr_data;

  // Window decode; the extra top bit is the borrow flagging addresses below BASE
  assign rd_diff = {1'b0, I_rd_addr} - BASE;
  assign wr_diff = {1'b0, I_wr_addr} - BASE;
  assign rd_off  = rd_diff[ADDR_WIDTH-1:0];
  assign wr_off  = wr_diff[ADDR_WIDTH-1:0];
  assign rd_hit  = !rd_diff[ADDR_WIDTH] && (rd_off < ADDR_WIDTH'(REG_COUNT));
  assign wr_hit  = I_wr_stb && !wr_diff[ADDR_WIDTH];

  assign wr_cmd     = wr_hit && (wr_off == ADDR_WIDTH'(REG_CMD));
  assign wr_status  = wr_hit && (wr_off == ADDR_WIDTH'(REG_STATUS));
  assign wr_mask    = wr_hit && (wr_off == ADDR_WIDTH'(REG_IRQ_MASK));
  assign wr_timeout = wr_hit && (wr_off == ADDR_WIDTH'(REG_TIMEOUT));
  assign wr_tmo     = wr_hit && (wr_off == ADDR_WIDTH'(REG_TMO_FLAGS));

  assign status_clr     = wr_status ? I_wr_data[NUM_STAT-1:0] : '0;
  assign unused_wr_data = ^I_wr_data;

  // Command channels
  for (genvar i = 0; i < NUM_CMD; i++) begin : g_ch
    hsci_cmd_channel #(
      .TIMEOUT_W (TIMEOUT_W)
    ) u_ch (
      .clk       (clk),
      .srstn     (srstn),
      .start_req (wr_cmd & I_wr_data[i]),
      .flag_clr  (wr_tmo & I_wr_data[i]),
      .done      (cmd_done[i]),
      .timeout   (timeout_q),
      .run       (cmd_run[i]),
      .start     (cmd_start[i]),
      .tmo_flag  (tmo_flags[i])
    );
  end

  // Status (set beats clear), mask, timeout, irq and read-data registers
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      status_q    <= '0;
      mask_q      <= '0;
      timeout_q   <= '0;
      irq         <= 1'b0;
      O_read_data <= '0;
    end else begin
      status_q <= (status_q & ~status_clr) | stat_event;
      if (wr_mask)    mask_q    <= I_wr_data[NUM_STAT-1:0];
      if (wr_timeout) timeout_q <= I_wr_data[TIMEOUT_W-1:0];
      irq         <= (|(status_q & mask_q)) | (|tmo_flags);
      O_read_data <= rdata_c;
    end
  end

  // Read mux over current (pre-write) register values
  always_comb begin
    rdata_c = '0;
    if (rd_hit) begin
      case (rd_off)
        ADDR_WIDTH'(REG_CMD):       rdata_c[NUM_CMD-1:0]   = cmd_run;
        ADDR_WIDTH'(REG_STATUS):    rdata_c[NUM_STAT-1:0]  = status_q;
        ADDR_WIDTH'(REG_IRQ_MASK):  rdata_c[NUM_STAT-1:0]  = mask_q;
        ADDR_WIDTH'(REG_TIMEOUT):   rdata_c[TIMEOUT_W-1:0] = timeout_q;
        ADDR_WIDTH'(REG_TMO_FLAGS): rdata_c[NUM_CMD-1:0]   = tmo_flags;
        ADDR_WIDTH'(REG_VERSION):   rdata_c                = DATA_WIDTH'(VERSION);
        default:                    rdata_c                = '0;
      endcase
    end
  end

endmodule

// File: doc/hsci_regmap_ctrl.md
Name: hsci_regmap_ctrl

Overview:
- Parametrised register-map control logic for HSCI-class masters.
- Generalises the single self-clearing run bit to NUM_CMD independent command channels. Each channel has a start/done handshake, a programmable timeout and a sticky timeout flag.
- Adds NUM_STAT sticky W1C status bits with a mask and a registered interrupt.
- Sits between the AXI register bridge (rd/wr strobe interface) and the datapath engines.

Parameters:
- ADDR_WIDTH, 10: register address width (word addressed).
- DATA_WIDTH, 32: register data width.
- NUM_CMD, 4: number of command channels, 1..DATA_WIDTH.
- NUM_STAT, 16: number of sticky status bits, 1..DATA_WIDTH.
- TIMEOUT_W, 16: timeout counter width, <= DATA_WIDTH.
- BASE_ADDR, 0: word offset of this block's register window.

Ports:
- clk  in  1  sole clock.
- srstn  in  1  reset; asynchronous assert, active-low.
- I_rd_addr  in  ADDR_WIDTH  read address; sampled every cycle.
- I_wr_stb  in  1  write strobe, one cycle per write.
- I_wr_addr  in  ADDR_WIDTH  write address.
- I_wr_data  in  DATA_WIDTH  write data.
- O_read_data  out  DATA_WIDTH  registered read data.
- cmd_run  out  NUM_CMD  per-channel busy level.
- cmd_start  out  NUM_CMD  per-channel single-cycle start pulse.
- cmd_done  in  NUM_CMD  per-channel completion; level or pulse.
- stat_event  in  NUM_STAT  status set requests, sampled every cycle.
- irq  out  1  registered interrupt, active-high.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 CMD: write 1 = start channel; read = cmd_run.
  - 1 STATUS: sticky, W1C.
  - 2 IRQ_MASK: RW, bits [NUM_STAT-1:0].
  - 3 TIMEOUT: RW, bits [TIMEOUT_W-1:0]; 0 = disabled.
  - 4 TMO_FLAGS: sticky, W1C, bits [NUM_CMD-1:0].
  - 5 VERSION: RO constant.
  - Unimplemented bits read 0. Writes to RO or unmapped addresses are ignored.
- Reset: every output and every register is 0. Channel FSMs go to IDLE.
- Read path:
  - O_read_data = value at I_rd_addr, registered; latency is 1 cycle.
  - Addresses outside the window read 0.
  - A read in the same cycle as a write to the same address returns the pre-write value.
- Channel FSM, per channel i, states IDLE and RUN:
  - IDLE -> RUN on a CMD write with bit i = 1. Next cycle: cmd_run[i] = 1, cmd_start[i] = 1 for exactly that cycle. The counter loads TIMEOUT.
  - RUN, cmd_done[i] = 1 (accepted in any RUN cycle, including the start-pulse cycle): next cycle IDLE, cmd_run[i] = 0.
  - RUN, TIMEOUT != 0: the counter decrements each RUN cycle. Reaching 0 without done forces IDLE and sets TMO_FLAGS[i]. A channel with TIMEOUT = T times out T cycles after the start pulse.
  - Done and timeout in the same cycle: done wins, no flag.
  - CMD write of 1 while in RUN is ignored; no restart and no pulse.
  - Writing 0 has no effect.
  - cmd_done in IDLE is ignored.
  - A TIMEOUT write during RUN affects only later starts.
- STATUS[j]:
  - Set when stat_event[j] = 1.
  - Cleared by a write of 1 to bit j.
  - Simultaneous set and clear: set wins.
  - TMO_FLAGS use the same rule; the timeout event beats W1C.
- irq: registered = |(STATUS & IRQ_MASK) | (|TMO_FLAGS). Lags the flag by 1 cycle.
- Reset asserted mid-RUN: run and start drop immediately (asynchronously); flags clear.

Decomposition:
- Package hsci_regmap_ctrl_pkg holds:
  - register offset localparams (REG_CMD..REG_VERSION);
  - VERSION value 32'h0001_0000;
  - cmd_state_t enum {CMD_IDLE, CMD_RUN}.
- Sub-module hsci_cmd_channel holds one FSM, the timeout counter and the flag set logic. It is instantiated NUM_CMD times in a generate loop.
- Top level holds address decode, STATUS, IRQ_MASK, TIMEOUT, the read mux and irq.

Test Plan:
- Single start: TIMEOUT = 0; write CMD = 0x1; cmd_done[0] pulses 5 cycles later.
  - cmd_start[0] is high for 1 cycle, 1 cycle after the write.
  - cmd_run[0] is high until 1 cycle after done.
  - Reading CMD returns 0x1 while running and 0x0 after.
- Timeout: TIMEOUT = 8; start channel 2; no done.
  - cmd_run[2] drops 8 cycles after the start pulse.
  - TMO_FLAGS = 0x4 and irq = 1 one cycle later.
  - W1C 0x4 clears the flag and irq.
- Race: done arrives on the exact cycle the counter hits 0 -> IDLE with TMO_FLAGS = 0.
- Restart ignored: write CMD = 0x1 twice while RUN -> only one cmd_start pulse.
- Status: stat_event = 0x0010 for 1 cycle; IRQ_MASK = 0.
  - STATUS = 0x0010, irq = 0.
  - Setting IRQ_MASK = 0x0010 gives irq = 1.
  - W1C 0x0010 in the same cycle as a new event leaves the bit set.
- Reset mid-operation: drop srstn while channels 0 and 3 are running -> all outputs 0 immediately; registers read 0 after release; VERSION reads 0x00010000.
